// File: rtl/qspi_flash_ctrl_if.sv
// Request/response bundle for the QSPI flash command sequencer.
// master = requester, slave = qspi_flash_ctrl.
interface qspi_flash_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/qspi_flash_ctrl.sv
// Byte-level read/write/erase sequencer for a nibble-wide QSPI flash.
// Ports: clk, reset_n, bus (slave: req/rsp handshakes), busy, mem_* strobes.
module qspi_flash_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int READ_LAT     = 1,
  parameter int ERASE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  qspi_flash_ctrl_if.slave  bus,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_nib_sel,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_erase,
  output logic [3:0]        mem_wdata,
  input  logic [3:0]        mem_rdata
);

  localparam int MAXW = (READ_LAT > ERASE_CYCLES) ?
                        READ_LAT : ERASE_CYCLES;
  localparam int CW = $clog2(MAXW + 1);
  localparam logic [CW-1:0] RL_LD = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] EC_LD =
    CW'((ERASE_CYCLES > 0) ? ERASE_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_LO_W,
    RD_HI, RD_HI_W, ERASE, ERASE_W, RSP
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        hi_q;
  logic [3:0]        lo_q;
  logic              rdy_q;
  logic              busy_q;
  logic              nib_q;
  logic              we_q;
  logic              re_q;
  logic              er_q;
  logic [3:0]        wd_q;
  logic              rv_q;
  logic [7:0]        rd_q;
  logic              err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      nib_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      er_q    <= 1'b0;
      wd_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // strobes are single-cycle unless a state re-raises them
      we_q <= 1'b0;
      re_q <= 1'b0;
      er_q <= 1'b0;
      wd_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            hi_q   <= bus.req_wdata[7:4];
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            nib_q  <= 1'b0;
            unique case (bus.req_cmd)
              2'b01: begin
                state_q <= RD_LO;
                re_q    <= 1'b1;
              end
              2'b10: begin
                state_q <= WR_LO;
                we_q    <= 1'b1;
                wd_q    <= bus.req_wdata[3:0];
              end
              2'b11: begin
                state_q <= ERASE;
                er_q    <= 1'b1;
              end
              default: begin
                state_q <= RSP;
                rv_q    <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        WR_LO: begin
          state_q <= WR_HI;
          we_q    <= 1'b1;
          nib_q   <= 1'b1;
          wd_q    <= hi_q;
        end
        WR_HI: begin
          state_q <= RSP;
          rv_q    <= 1'b1;
        end
        RD_LO: begin
          state_q <= RD_LO_W;
          cnt_q   <= RL_LD;
        end
        RD_LO_W: begin
          if (cnt_q == '0) begin
            lo_q    <= mem_rdata;
            state_q <= RD_HI;
            re_q    <= 1'b1;
            nib_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RD_HI: begin
          state_q <= RD_HI_W;
          cnt_q   <= RL_LD;
        end
        RD_HI_W: begin
          if (cnt_q == '0) begin
            rd_q    <= {mem_rdata, lo_q};
            rv_q    <= 1'b1;
            state_q <= RSP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ERASE: begin
          if (ERASE_CYCLES == 0) begin
            rv_q    <= 1'b1;
            state_q <= RSP;
          end else begin
            cnt_q   <= EC_LD;
            state_q <= ERASE_W;
          end
        end
        ERASE_W: begin
          if (cnt_q == '0) begin
            rv_q    <= 1'b1;
            state_q <= RSP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rv_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rd_q;
  assign bus.rsp_err   = err_q;
  assign busy          = busy_q;
  assign mem_addr      = addr_q;
  assign mem_nib_sel   = nib_q;
  assign mem_we        = we_q;
  assign mem_re        = re_q;
  assign mem_erase     = er_q;
  assign mem_wdata     = wd_q;

endmodule
